// File: rtl/clk_gen_pkg.sv
// Shared constants, channel-state type and width helper for the clock-enable generator.
package clk_gen_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned NCH_DEF     = 4;
    localparam int unsigned DIV_W_DEF   = 16;
    localparam int unsigned DEF_DIV_DEF = 999;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    // Channel-select width; a single channel still needs a 1-bit select port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W_DEF = ch_width(NCH_DEF);

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle between the board top level and the clock-enable generator.
interface clk_div_gen_if #(
    parameter int unsigned CNT_W = clk_gen_pkg::CNT_W_DEF,
    parameter int unsigned NCH   = clk_gen_pkg::NCH_DEF,
    parameter int unsigned DIV_W = clk_gen_pkg::DIV_W_DEF
);
    localparam int unsigned CH_W = clk_gen_pkg::ch_width(NCH);

    logic             en;
    logic [NCH-1:0]   chan_en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] clkdiv;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;

    modport master (
        output en, chan_en, cfg_we, cfg_ch, cfg_div,
        input  clkdiv, tick, sq
    );

    modport slave (
        input  en, chan_en, cfg_we, cfg_ch, cfg_div,
        output clkdiv, tick, sq
    );

endinterface

// File: rtl/clk_div_chan.sv
// One programmable divider channel: one-cycle tick enable plus toggling square wave.
module clk_div_chan
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             chan_en_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_a_q;
    logic [DIV_W-1:0] div_p_q;
    logic [DIV_W-1:0] div_nxt_c;
    logic             tick_q;
    logic             sq_q;
    chan_state_e      state_c;

    assign state_c   = chan_en_i ? RUN : IDLE;
    // A write landing on the wrap cycle bypasses the pending register.
    assign div_nxt_c = wr_i ? wr_div_i : div_p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_p_q <= DIV_W'(DEF_DIV);
        end else if (wr_i) begin
            div_p_q <= wr_div_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_a_q <= DIV_W'(DEF_DIV);
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            case (state_c)
                IDLE: begin
                    cnt_q   <= '0;
                    tick_q  <= 1'b0;
                    sq_q    <= 1'b0;
                    div_a_q <= div_nxt_c;
                end
                RUN: begin
                    if (!en_i) begin
                        tick_q <= 1'b0;
                    end else if (cnt_q == div_a_q) begin
                        cnt_q   <= '0;
                        tick_q  <= 1'b1;
                        sq_q    <= ~sq_q;
                        div_a_q <= div_nxt_c;
                    end else begin
                        cnt_q  <= cnt_q + DIV_W'(1);
                        tick_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/clk_div_gen.sv
// Clock-enable generator: legacy free-running clkdiv counter plus NCH programmable divider channels.
module clk_div_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned NCH     = NCH_DEF,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_gen_if.slave  bus
);

    localparam int unsigned CH_W = ch_width(NCH);

    logic [CNT_W-1:0] clkdiv_q;
    logic             cfg_ok_c;
    logic [NCH-1:0]   tick_c;
    logic [NCH-1:0]   sq_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q <= '0;
        end else if (bus.en) begin
            clkdiv_q <= clkdiv_q + CNT_W'(1);
        end
    end

    // Writes addressed past the last channel are dropped.
    assign cfg_ok_c = bus.cfg_we && (32'(bus.cfg_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic wr_c;
        assign wr_c = cfg_ok_c && (bus.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (bus.en),
            .chan_en_i (bus.chan_en[i]),
            .wr_i      (wr_c),
            .wr_div_i  (bus.cfg_div),
            .tick_o    (tick_c[i]),
            .sq_o      (sq_c[i])
        );
    end

    assign bus.clkdiv = clkdiv_q;
    assign bus.tick   = tick_c;
    assign bus.sq     = sq_c;

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised clock-enable generator for the board top level; successor to the single free-running divider. It keeps the free-running `clkdiv` bus for legacy consumers. It adds NCH independently programmable divider channels, each producing a one-cycle `tick` enable and a 50%-style toggling square wave `sq`. Everything runs in the single system clock domain, so downstream logic uses clock enables instead of derived clocks.

## Interface
- `CNT_W`, 32, width of free-running `clkdiv` counter
- `NCH`, 4, number of divider channels (≥1)
- `DIV_W`, 16, width of per-channel divide value
- `DEF_DIV`, 999, divide value loaded into every channel at reset
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  global count enable; low freezes all counters
- `chan_en`  in  NCH  per-channel enable
- `cfg_we`  in  1  divide-value write strobe, single cycle
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel of write
- `cfg_div`  in  DIV_W  divide value to write
- `clkdiv`  out  CNT_W  free-running counter
- `tick`  out  NCH  one-cycle enable pulse per channel period
- `sq`  out  NCH  square wave, toggles on each tick

## Operation
- `clkdiv`: +1 on every `clk` edge with `en`=1; wraps from 2^CNT_W−1 to 0; holds when `en`=0.
- Per channel i: active divide `div_a`, pending divide `div_p`, counter `cnt` (DIV_W bits).
- Channel states:
  - IDLE (`chan_en[i]`=0): `cnt`=0, `tick`=0, `sq`=0; `div_a` follows `div_p` every cycle.
  - RUN (`chan_en[i]`=1): advances only when `en`=1.
- RUN step with `en`=1:
  - if `cnt`==`div_a`: `cnt`←0, `tick`←1, `sq`←~`sq`, `div_a`←next pending value;
  - else: `cnt`←`cnt`+1, `tick`←0.
- Period is `div_a`+1 enabled cycles. `div`=0 gives `tick` high every enabled cycle and `sq` toggling every cycle.
- RUN with `en`=0: `cnt`, `sq`, `div_a` hold; `tick`←0.
- Config write: `cfg_we`=1 writes `cfg_div` into `div_p[cfg_ch]`. A write with `cfg_ch`≥NCH is ignored.
- A new value never truncates a running period; it takes effect at the next wrap.
- Write in the same cycle as the wrap: the written value bypasses into `div_a` at that wrap.
- Clearing `chan_en[i]` mid-period returns the channel to IDLE next edge; partial count is discarded.
- Reset (any time, asynchronous): `clkdiv`=0, all `cnt`=0, `tick`=0, `sq`=0, `div_a`=`div_p`=`DEF_DIV`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `tick[i]` is high for exactly one cycle. It is asserted in the cycle after the edge at which `cnt`==`div_a` is sampled with `en`=1.
- First tick after `chan_en[i]` rises, assuming `en` held 1: `tick` is high in the (D+1)th cycle after the first edge that samples `chan_en`=1, where D = `div_a`.
- `sq` changes on the same edge that asserts `tick`; its period is 2·(D+1) cycles.
- Config write latency: visible in `div_p` one edge after `cfg_we`; affects output only from the next wrap.
- Reset deassertion is not synchronised internally. `rst_n` must be released synchronously by the top-level reset synchroniser.

## Structure
- Package `clk_gen_pkg`:
  - default parameter constants (`CNT_W`, `DIV_W`, `DEF_DIV`);
  - channel-state enum {IDLE, RUN};
  - helper localparam for `cfg_ch` width.
- Sub-module `clk_div_chan` (one divider channel: `cnt`, `div_a`, `div_p`, `tick`, `sq`), instantiated NCH times via generate.
- The top level holds the `clkdiv` counter and the `cfg_ch` decode / out-of-range ignore.

## Test plan
- Reset with `rst_n`=0 mid-count, then release -> all outputs 0; channel 0 with `DEF_DIV`=999 ticks 1000 cycles after enable; `clkdiv` counts 0,1,2….
- `CNT_W`=4, `en`=1 for 20 cycles -> `clkdiv` wraps 15→0; `en`=0 for 5 cycles -> `clkdiv`, `cnt`, `sq` frozen and `tick`=0.
- Channel 1 div=3, then write div=1 mid-period -> ticks 4 cycles apart until the next wrap, then 2 cycles apart; `sq` period goes 8→4.
- div=0 on channel 2 -> `tick[2]` continuously 1, `sq[2]` toggles every cycle; writing `cfg_ch`=NCH with div=5 changes no channel.
- Write div=7 in the exact cycle of a div=2 wrap -> the next period is 8 cycles (bypass). Dropping `chan_en` mid-period -> `cnt`/`sq`/`tick` return to 0 the next cycle; re-enabling gives a full period.
